// File: rtl/udma_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// udma_xfer_ctrl
//
// Grant-consuming transfer controller for uDMA channels. It presents a request
// vector to an external round-robin arbiter, accepts the one-hot grant, issues
// one L2 beat at the granted channel's current address, and acknowledges the
// arbiter so that its priority advances. Per-channel address / remaining-byte
// counters are kept here, and a done pulse marks the last beat of a transfer.
//
// Optional feature macro: UDMA_XFER_CONTINUOUS_EN
//   defined   -> channels with cfg_continuous_i[n]=1 reload their start
//                address/size on the last beat and stay active.
//   undefined -> cfg_continuous_i is ignored, reload registers are absent,
//                every completion clears the channel.
//
// Ports
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   cfg_start_i[N]        start pulse: load addr/size/datasize, set active
//   cfg_stop_i[N]         stop pulse: clear active (stop wins over start)
//   cfg_addr_i            shared start byte address
//   cfg_size_i            transfer length in bytes (0 = start ignored)
//   cfg_datasize_i        beat size code: 0=1B, 1=2B, 2/3=4B
//   cfg_continuous_i[N]   per-channel auto-reload enable
//   ch_valid_i[N]         channel has a beat ready
//   ch_busy_o[N]          channel active
//   ch_ack_o[N]           beat accepted by L2 (one-cycle pulse)
//   ch_done_o[N]          transfer complete (one-cycle pulse)
//   arb_req_o[N]          request vector to arbiter
//   arb_grant_i[N]        one-hot grant from arbiter
//   arb_any_grant_i       arbiter has a grant
//   arb_grant_ack_o       acknowledge to arbiter (same cycle as grant in IDLE)
//   l2_req_o              L2 request, held until l2_gnt_i
//   l2_addr_o, l2_size_o  L2 byte address and beat size code
//   l2_gnt_i              L2 grant
// -----------------------------------------------------------------------------
module udma_xfer_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned L2_AWIDTH  = 19,
    parameter int unsigned TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [N-1:0]          cfg_start_i,
    input  logic [N-1:0]          cfg_stop_i,
    input  logic [L2_AWIDTH-1:0]  cfg_addr_i,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic [1:0]            cfg_datasize_i,
    input  logic [N-1:0]          cfg_continuous_i,
    input  logic [N-1:0]          ch_valid_i,
    output logic [N-1:0]          ch_busy_o,
    output logic [N-1:0]          ch_ack_o,
    output logic [N-1:0]          ch_done_o,
    output logic [N-1:0]          arb_req_o,
    input  logic [N-1:0]          arb_grant_i,
    input  logic                  arb_any_grant_i,
    output logic                  arb_grant_ack_o,
    output logic                  l2_req_o,
    output logic [L2_AWIDTH-1:0]  l2_addr_o,
    output logic [1:0]            l2_size_o,
    input  logic                  l2_gnt_i
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Beat size code to byte count; code 3 behaves like 4 bytes.
    function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
        logic [2:0] b;
        case (ds)
            2'd0:    b = 3'd1;
            2'd1:    b = 3'd2;
            default: b = 3'd4;
        endcase
        return b;
    endfunction

    // One-hot to binary index (grant is one-hot, so OR-ing indices is exact).
    function automatic logic [CW-1:0] onehot_enc(input logic [N-1:0] oh);
        logic [CW-1:0] enc;
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                enc = enc | CW'(i);
            end else begin
                enc = enc;
            end
        end
        return enc;
    endfunction

    state_e                state_q;
    logic [CW-1:0]         ch_q;
    logic [N-1:0]          active_q;
    logic [L2_AWIDTH-1:0]  addr_q  [N];
    logic [TRANS_SIZE-1:0] size_q  [N];
    logic [1:0]            dsize_q [N];
`ifdef UDMA_XFER_CONTINUOUS_EN
    logic [L2_AWIDTH-1:0]  addr0_q [N];
    logic [TRANS_SIZE-1:0] size0_q [N];
`else
    logic                  unused_cont_s;
    assign unused_cont_s = ^cfg_continuous_i;
`endif

    logic [TRANS_SIZE-1:0] cur_bytes_s;
    logic                  cur_live_s;
    logic                  cur_last_s;
    logic                  beat_s;
    logic [N-1:0]          upd_s;
    logic [N-1:0]          start_ok_s;
    logic [N-1:0]          ack_s;
    logic [N-1:0]          done_s;

    // A beat only advances counters if its channel is still running; a channel
    // stopped while its beat is outstanding still gets its ack but nothing else.
    assign cur_bytes_s = TRANS_SIZE'(beat_bytes(dsize_q[ch_q]));
    assign cur_live_s  = active_q[ch_q] & ~cfg_stop_i[ch_q];
    assign cur_last_s  = (size_q[ch_q] <= cur_bytes_s);
    assign beat_s      = (state_q == ST_REQ) & l2_gnt_i;
    assign start_ok_s  = cfg_start_i & ~active_q & {N{cfg_size_i != {TRANS_SIZE{1'b0}}}};

    // Per-channel beat acknowledge, done pulse and counter-update enables.
    always_comb begin
        ack_s  = '0;
        done_s = '0;
        upd_s  = '0;
        if (beat_s) begin
            ack_s[ch_q] = 1'b1;
            if (cur_live_s) begin
                upd_s[ch_q]  = 1'b1;
                done_s[ch_q] = cur_last_s;
            end else begin
                upd_s[ch_q]  = 1'b0;
                done_s[ch_q] = 1'b0;
            end
        end else begin
            ack_s  = '0;
            done_s = '0;
            upd_s  = '0;
        end
    end

    assign arb_req_o       = active_q & ch_valid_i;
    assign arb_grant_ack_o = (state_q == ST_IDLE) & arb_any_grant_i;
    assign l2_req_o        = (state_q == ST_REQ);
    assign l2_addr_o       = addr_q[ch_q];
    assign l2_size_o       = dsize_q[ch_q];
    assign ch_busy_o       = active_q;
    assign ch_ack_o        = ack_s;
    assign ch_done_o       = done_s;

    // Transfer FSM: latch the granted channel, then hold the L2 request.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any_grant_i) begin
                        ch_q    <= onehot_enc(arb_grant_i);
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (l2_gnt_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-channel configuration and progress registers (stop > beat > start).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            active_q <= '0;
            for (int n = 0; n < N; n++) begin
                addr_q[n]  <= '0;
                size_q[n]  <= '0;
                dsize_q[n] <= 2'd0;
`ifdef UDMA_XFER_CONTINUOUS_EN
                addr0_q[n] <= '0;
                size0_q[n] <= '0;
`endif
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                if (cfg_stop_i[n]) begin
                    active_q[n] <= 1'b0;
                end else if (upd_s[n]) begin
                    if (!cur_last_s) begin
                        size_q[n] <= size_q[n] - cur_bytes_s;
                        addr_q[n] <= addr_q[n] + L2_AWIDTH'(cur_bytes_s);
`ifdef UDMA_XFER_CONTINUOUS_EN
                    end else if (cfg_continuous_i[n]) begin
                        addr_q[n] <= addr0_q[n];
                        size_q[n] <= size0_q[n];
`endif
                    end else begin
                        active_q[n] <= 1'b0;
                    end
                end else if (start_ok_s[n]) begin
                    active_q[n] <= 1'b1;
                    addr_q[n]   <= cfg_addr_i;
                    size_q[n]   <= cfg_size_i;
                    dsize_q[n]  <= cfg_datasize_i;
`ifdef UDMA_XFER_CONTINUOUS_EN
                    addr0_q[n]  <= cfg_addr_i;
                    size0_q[n]  <= cfg_size_i;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_udma_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_udma_xfer_ctrl
//
// Bench for udma_xfer_ctrl: a round-robin arbiter model is attached to the
// request/grant ports; a transaction-level reference model (integers per
// channel) predicts every output each cycle. Directed scenarios are followed by
// a randomized phase. UDMA_XFER_CONTINUOUS_EN selects the matching model rule.
// -----------------------------------------------------------------------------
module tb_udma_xfer_ctrl;

    localparam int N   = 8;
    localparam int AW  = 19;
    localparam int TS  = 16;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  cfg_start, cfg_stop, cfg_cont, ch_valid;
    logic [AW-1:0] cfg_addr;
    logic [TS-1:0] cfg_size;
    logic [1:0]    cfg_ds;
    logic [N-1:0]  ch_busy, ch_ack, ch_done, arb_req, arb_grant;
    logic          arb_any, arb_ack, l2_req, l2_gnt;
    logic [AW-1:0] l2_addr;
    logic [1:0]    l2_size;

    udma_xfer_ctrl #(.N(N), .L2_AWIDTH(AW), .TRANS_SIZE(TS)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
        .cfg_addr_i(cfg_addr), .cfg_size_i(cfg_size), .cfg_datasize_i(cfg_ds),
        .cfg_continuous_i(cfg_cont), .ch_valid_i(ch_valid),
        .ch_busy_o(ch_busy), .ch_ack_o(ch_ack), .ch_done_o(ch_done),
        .arb_req_o(arb_req), .arb_grant_i(arb_grant), .arb_any_grant_i(arb_any),
        .arb_grant_ack_o(arb_ack),
        .l2_req_o(l2_req), .l2_addr_o(l2_addr), .l2_size_o(l2_size), .l2_gnt_i(l2_gnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int bb(input int ds);
        return (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    endfunction

    // Round-robin arbiter: search starts one past the last acknowledged channel.
    logic [2:0] ptr;
    logic       found;
    always_comb begin
        arb_grant = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && arb_req[3'(int'(ptr) + k)]) begin
                arb_grant[3'(int'(ptr) + k)] = 1'b1;
                found = 1'b1;
            end
        end
    end
    assign arb_any = |arb_grant;

    // Arbiter priority pointer advances on acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr <= 3'd0;
        else if (arb_ack) ptr <= 3'(enc(arb_grant) + 1);
    end

    // Reference model state and scenario logs
    logic [N-1:0] m_active;
    int  m_addr[N], m_rem[N], m_ds[N], m_addr0[N], m_rem0[N];
    bit  m_inreq;
    int  m_cur;
    int  log_ch[$], log_addr[$], log_done[$];
    int  done_cnt[N];
    int  arb_ack_cnt;

    // Compare process: predict outputs from the model, check, then advance.
    initial begin : compare
        int bytes;
        logic [N-1:0] e_ack, e_done;
        bit e_arb_ack;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_active = '0;
                m_inreq  = 1'b0;
                m_cur    = 0;
                for (int n = 0; n < N; n++) begin
                    m_addr[n] = 0; m_rem[n] = 0; m_ds[n] = 0;
                end
            end else begin
                check("busy", ch_busy, m_active);
                check("arb_req", arb_req, m_active & ch_valid);
                e_arb_ack = !m_inreq && (arb_grant != '0);
                check("arb_ack", arb_ack, e_arb_ack);
                check("l2_req", l2_req, m_inreq);
                e_ack  = '0;
                e_done = '0;
                bytes  = 0;
                if (m_inreq) begin
                    check("l2_addr", l2_addr, m_addr[m_cur]);
                    check("l2_size", l2_size, m_ds[m_cur]);
                    bytes = bb(m_ds[m_cur]);
                    if (l2_gnt) begin
                        e_ack[m_cur] = 1'b1;
                        if (m_active[m_cur] && !cfg_stop[m_cur] && m_rem[m_cur] <= bytes)
                            e_done[m_cur] = 1'b1;
                    end
                end
                check("ch_ack", ch_ack, e_ack);
                check("ch_done", ch_done, e_done);
                if (e_arb_ack) arb_ack_cnt++;
                if (e_ack != '0) begin
                    log_ch.push_back(m_cur);
                    log_addr.push_back(m_addr[m_cur]);
                    log_done.push_back(int'(e_done[m_cur]));
                    if (e_done[m_cur]) done_cnt[m_cur]++;
                end
                for (int n = 0; n < N; n++) begin
                    if (cfg_stop[n]) begin
                        m_active[n] = 1'b0;
                    end else if (e_ack[n] && m_active[n]) begin
                        if (m_rem[n] > bytes) begin
                            m_rem[n]  = m_rem[n] - bytes;
                            m_addr[n] = (m_addr[n] + bytes) % AMOD;
                        end else begin
`ifdef UDMA_XFER_CONTINUOUS_EN
                            if (cfg_cont[n]) begin
                                m_addr[n] = m_addr0[n];
                                m_rem[n]  = m_rem0[n];
                            end else m_active[n] = 1'b0;
`else
                            m_active[n] = 1'b0;
`endif
                        end
                    end else if (cfg_start[n] && !m_active[n] && cfg_size != 0) begin
                        m_active[n] = 1'b1;
                        m_addr[n]   = int'(cfg_addr);
                        m_rem[n]    = int'(cfg_size);
                        m_ds[n]     = int'(cfg_ds);
                        m_addr0[n]  = int'(cfg_addr);
                        m_rem0[n]   = int'(cfg_size);
                    end
                end
                if (!m_inreq && arb_grant != '0) begin
                    m_inreq = 1'b1;
                    m_cur   = enc(arb_grant);
                end else if (m_inreq && l2_gnt) begin
                    m_inreq = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_ch.delete(); log_addr.delete(); log_done.delete();
        for (int n = 0; n < N; n++) done_cnt[n] = 0;
        arb_ack_cnt = 0;
    endtask

    task automatic start_ch(input int n, input int addr, input int size, input int ds);
        cfg_addr  = AW'(addr);
        cfg_size  = TS'(size);
        cfg_ds    = 2'(ds);
        cfg_start = '0;
        cfg_start[n] = 1'b1;
        cyc();
        cfg_start = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((ch_busy != '0 || l2_req) && k < budget) begin cyc(); k++; end
        check(name, longint'(k < budget), 1);
    endtask

    task automatic wait_req(input string name, input int budget);
        int k = 0;
        while (!l2_req && k < budget) begin cyc(); k++; end
        check(name, longint'(k < budget), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rstn = 1'b0; cfg_start = '0; cfg_stop = '0; cfg_cont = '0; ch_valid = '0;
        cfg_addr = '0; cfg_size = '0; cfg_ds = 2'd0; l2_gnt = 1'b0;
        clear_logs();
        repeat (3) cyc();
        // Reset state
        check("rst_busy", ch_busy, 0);
        check("rst_l2_req", l2_req, 0);
        check("rst_l2_addr", l2_addr, 0);
        check("rst_l2_size", l2_size, 0);
        check("rst_arb_ack", arb_ack, 0);
        check("rst_ack_done", {ch_ack, ch_done}, 0);
        rstn = 1'b1;
        cyc();

        // Single channel: two 4-byte beats
        ch_valid = '1; l2_gnt = 1'b1; clear_logs();
        start_ch(2, 'h100, 8, 2);
        wait_idle("t1_idle", 50);
        check("t1_beats", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t1_addr0", log_addr[0], 'h100);
            check("t1_addr1", log_addr[1], 'h104);
            check("t1_done_last", log_done[1], 1);
        end
        check("t1_done_cnt", done_cnt[2], 1);
        check("t1_busy", ch_busy[2], 0);

        // L2 back-pressure: request and address held, one arbiter ack
        l2_gnt = 1'b0; clear_logs();
        start_ch(5, 'h40, 4, 2);
        wait_req("t2_req", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_req", l2_req, 1);
            check("t2_hold_addr", l2_addr, 'h40);
            cyc();
        end
        l2_gnt = 1'b1;
        wait_idle("t2_idle", 50);
        check("t2_arb_acks", arb_ack_cnt, 1);
        check("t2_done", done_cnt[5], 1);

        // Two channels alternate under round-robin
        clear_logs();
        cfg_addr = AW'('h10); cfg_size = TS'(4); cfg_ds = 2'd0;
        cfg_start = 8'b0000_0011;
        cyc();
        cfg_start = '0;
        wait_idle("t3_idle", 100);
        check("t3_beats", log_ch.size(), 8);
        if (log_ch.size() == 8) begin
            for (int i = 1; i < 8; i++) check("t3_alternate", longint'(log_ch[i] != log_ch[i-1]), 1);
            check("t3_last_addr", log_addr[7], 'h13);
        end
        check("t3_done0", done_cnt[0], 1);
        check("t3_done1", done_cnt[1], 1);

        // Stop during REQ: beat still acked, no done
        l2_gnt = 1'b0; clear_logs();
        start_ch(3, 'h300, 16, 2);
        wait_req("t4_req", 20);
        cfg_stop[3] = 1'b1;
        cyc();
        cfg_stop = '0;
        cyc();
        l2_gnt = 1'b1;
        wait_idle("t4_idle", 50);
        check("t4_beats", log_ch.size(), 1);
        check("t4_done", done_cnt[3], 0);
        check("t4_busy", ch_busy[3], 0);

        // Address wrap with odd size
        clear_logs();
        start_ch(4, 'h7FFFE, 3, 1);
        wait_idle("t5_idle", 50);
        check("t5_beats", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t5_addr0", log_addr[0], 'h7FFFE);
            check("t5_addr1", log_addr[1], 'h00000);
            check("t5_done_first", log_done[0], 0);
            check("t5_done_second", log_done[1], 1);
        end

        // Continuous mode
        clear_logs();
        cfg_cont[6] = 1'b1;
        start_ch(6, 'h200, 4, 2);
        repeat (12) cyc();
`ifdef UDMA_XFER_CONTINUOUS_EN
        check("t6_many_done", longint'(done_cnt[6] >= 3), 1);
        check("t6_busy", ch_busy[6], 1);
        foreach (log_addr[i]) check("t6_addr", log_addr[i], 'h200);
        cfg_stop[6] = 1'b1;
        cyc();
        cfg_stop = '0;
`else
        check("t6_one_done", done_cnt[6], 1);
        check("t6_busy", ch_busy[6], 0);
`endif
        cfg_cont = '0;
        wait_idle("t6_idle", 50);

        // Reset asserted mid-REQ drops request immediately
        l2_gnt = 1'b0;
        start_ch(1, 'h55, 8, 0);
        wait_req("t7_req", 20);
        rstn = 1'b0;
        #1;
        check("t7_req_drop", l2_req, 0);
        check("t7_busy_clear", ch_busy, 0);
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            ch_valid  = N'($urandom);
            l2_gnt    = ($urandom_range(0, 9) < 7);
            cfg_start = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cfg_stop  = '0;
            if ($urandom_range(0, 19) == 0) cfg_stop[$urandom_range(0, N-1)] = 1'b1;
            if (c % 50 == 0) cfg_cont = N'($urandom);
            cfg_addr  = AW'($urandom);
            cfg_size  = TS'($urandom_range(0, 12));
            cfg_ds    = 2'($urandom_range(0, 3));
            cyc();
        end
        cfg_start = '0; cfg_stop = '1; l2_gnt = 1'b1;
        cyc();
        cfg_stop = '0;
        wait_idle("rand_drain", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
